i2s_apb_regs: RTL and testbench

Parametrised APB register bank for the I2S transceiver, replacing the fixed four-word register file. It holds the control word and exposes the core status flags. It buffers transmit and receive samples in DEPTH-entry FIFOs, so software can feed and drain whole frames rather than single words. It also provides sticky, maskable error flags with an interrupt output. It sits between the APB bus and the I2S Tx/Rx cores.

---
 rtl/i2s_apb_regs.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_apb_regs.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_apb_regs.sv
// ============================================================================
// Module   : i2s_apb_regs
// Brief    : APB register bank for the I2S transceiver: control word, status,
//            DEPTH-entry Tx/Rx sample FIFOs and sticky maskable error flags.
//            Optional macro I2S_REGS_IRQ_EN builds IRQ_STAT/IRQ_EN and irq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_apb_regs #(
    parameter int                CTRL_W   = 15,
    parameter logic [CTRL_W-1:0] CTRL_RST = 15'h06D5,
    parameter int                FLAG_W   = 13,
    parameter int                DEPTH    = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [CTRL_W-1:0] controls,
    input  logic [FLAG_W-1:0] flags,
    input  logic              tx_rd,
    output logic [31:0]       tx_data,
    output logic              tx_empty,
    input  logic              rx_wr,
    input  logic [31:0]       rx_data,
    output logic              rx_full,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_TXDATA = 6'd2;
    localparam logic [5:0] A_RXDATA = 6'd3;
`ifdef I2S_REGS_IRQ_EN
    localparam logic [5:0] A_IRQ_STAT = 6'd4;
    localparam logic [5:0] A_IRQ_EN   = 6'd5;
`endif

    logic              setup_ph;
    logic              access_ph;
    logic [5:0]        word;
    logic              mapped;
    logic              wr_acc;
    logic              rd_acc;
    logic [31:0]       rdata;
    logic [CTRL_W-1:0] ctrl;

    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;

    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [CW-1:0] rx_count;
    logic          rx_empty;
    logic          rx_pop_req;
    logic          rx_push;
    logic          rx_pop;

    logic          unused_ok;

    assign setup_ph  = psel & ~penable;
    assign access_ph = psel & penable;
    assign word      = paddr[7:2];
    assign wr_acc    = access_ph & pwrite & mapped;
    assign rd_acc    = access_ph & ~pwrite & mapped;
    assign pready    = 1'b1;
    assign controls  = ctrl;
    assign unused_ok = &{1'b0, paddr[1:0]};

    always_comb begin
        mapped = 1'b0;
        case (word)
            A_CTRL, A_STATUS, A_TXDATA, A_RXDATA: mapped = 1'b1;
`ifdef I2S_REGS_IRQ_EN
            A_IRQ_STAT, A_IRQ_EN:                 mapped = 1'b1;
`endif
            default:                              mapped = 1'b0;
        endcase
    end

    // Full/empty come from the pre-edge count, so a push into a full FIFO is
    // dropped even when the core pops in the same cycle.
    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_empty    = (tx_count == '0);
    assign tx_push_req = wr_acc & (word == A_TXDATA);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = tx_rd & ~tx_empty;
    assign tx_data     = tx_empty ? 32'h0 : tx_mem[tx_rptr];

    assign rx_full     = (rx_count == FULL_CNT);
    assign rx_empty    = (rx_count == '0);
    assign rx_pop_req  = rd_acc & (word == A_RXDATA);
    assign rx_pop      = rx_pop_req & ~rx_empty;
    assign rx_push     = rx_wr & ~rx_full;

    always_ff @(posedge pclk) begin
        if (tx_push) tx_mem[tx_wptr] <= pwdata;
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl <= CTRL_RST;
        end else if (wr_acc && word == A_CTRL) begin
            ctrl <= pwdata[CTRL_W-1:0];
        end
    end

`ifdef I2S_REGS_IRQ_EN
    logic [3:0] irq_stat;
    logic [3:0] irq_en;
    logic [3:0] irq_set;
    logic [3:0] irq_clr;

    assign irq_set = {tx_rd & tx_empty, rx_wr & rx_full,
                      rx_pop_req & rx_empty, tx_push_req & tx_full};
    assign irq_clr = (wr_acc && word == A_IRQ_STAT) ? pwdata[3:0] : 4'b0;

    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    always_ff @(posedge pclk) begin
        if (preset) begin
            irq_stat <= 4'b0;
            irq_en   <= 4'b0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            if (wr_acc && word == A_IRQ_EN) irq_en <= pwdata[3:0];
            irq <= |(irq_stat & irq_en);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        case (word)
            A_CTRL:     rdata = 32'(ctrl);
            A_STATUS:   rdata = {8'(rx_count), 8'(tx_count), 16'(flags)};
            A_RXDATA:   rdata = rx_empty ? 32'h0 : rx_mem[rx_rptr];
`ifdef I2S_REGS_IRQ_EN
            A_IRQ_STAT: rdata = 32'(irq_stat);
            A_IRQ_EN:   rdata = 32'(irq_en);
`endif
            default:    rdata = 32'h0;
        endcase
    end

    // Read data and the error response are captured at the setup edge and
    // held through the access phase.
    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata  <= 32'h0;
            pslverr <= 1'b0;
        end else if (setup_ph) begin
            prdata  <= pwrite ? 32'h0 : rdata;
            pslverr <= ~mapped;
        end else begin
            pslverr <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_apb_regs.sv
// ============================================================================
// Module   : tb_i2s_apb_regs
// Brief    : Self-checking bench for i2s_apb_regs against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_apb_regs;

    localparam int DEPTH = 4;
`ifdef I2S_REGS_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = 8'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [14:0] controls;
    logic [12:0] flags = 13'h0;
    logic        tx_rd = 1'b0;
    logic [31:0] tx_data;
    logic        tx_empty;
    logic        rx_wr = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic        rx_full;
    logic        irq;

    i2s_apb_regs dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .controls(controls), .flags(flags),
        .tx_rd(tx_rd), .tx_data(tx_data), .tx_empty(tx_empty), .rx_wr(rx_wr),
        .rx_data(rx_data), .rx_full(rx_full), .irq(irq)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues and sticky bit vectors
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [3:0]  m_stat;
    logic [3:0]  m_en;
    logic [14:0] m_ctrl;

    function automatic logic exp_irq();
        return IRQ_ON ? |(m_stat & m_en) : 1'b0;
    endfunction

    function automatic logic [31:0] exp_head();
        return (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    endfunction

    function automatic void model_reset();
        tx_q.delete();
        rx_q.delete();
        m_stat = 4'h0;
        m_en   = 4'h0;
        m_ctrl = 15'h06D5;
    endfunction

    function automatic void model_access(input logic [7:0] a, input logic wr,
                                         input logic [31:0] wd, input logic pop_too,
                                         output logic [31:0] ed, output logic ee);
        int w;
        int pre_tx;
        logic [3:0] set;
        logic [3:0] clr;
        w = int'(a[7:2]);
        pre_tx = tx_q.size();
        set = 4'h0;
        clr = 4'h0;
        ed = 32'h0;
        ee = 1'b0;
        case (w)
            0: if (wr) m_ctrl = wd[14:0]; else ed = 32'(m_ctrl);
            1: if (!wr) ed = {8'(rx_q.size()), 8'(tx_q.size()), 16'(flags)};
            2: if (wr && pre_tx == DEPTH) set[0] = 1'b1;
            3: if (!wr) begin
                   if (rx_q.size() == 0) set[1] = 1'b1;
                   else ed = rx_q.pop_front();
               end
            4: if (IRQ_ON) begin if (wr) clr = wd[3:0]; else ed = 32'(m_stat); end
               else ee = 1'b1;
            5: if (IRQ_ON) begin if (wr) m_en = wd[3:0]; else ed = 32'(m_en); end
               else ee = 1'b1;
            default: ee = 1'b1;
        endcase
        if (pop_too) begin
            if (pre_tx == 0) set[3] = 1'b1;
            else void'(tx_q.pop_front());
        end
        if (w == 2 && wr && pre_tx < DEPTH) tx_q.push_back(wd);
        if (IRQ_ON) m_stat = (m_stat & ~clr) | set;
    endfunction

    task automatic apb(input logic [7:0] a, input logic wr, input logic [31:0] wd,
                       input logic pop_too, output logic [31:0] d, output logic e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1; tx_rd = pop_too;
        d = prdata; e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_rd = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] a, input logic wr, input logic [31:0] wd,
                        input logic pop_too, output logic [31:0] d, output logic e,
                        output logic [31:0] ed, output logic ee);
        model_access(a, wr, wd, pop_too, ed, ee);
        apb(a, wr, wd, pop_too, d, e);
    endtask

    task automatic rx_push(input logic [31:0] v);
        @(posedge pclk); #1;
        rx_wr = 1'b1; rx_data = v;
        @(posedge pclk); #1;
        rx_wr = 1'b0;
        if (rx_q.size() == DEPTH) begin
            if (IRQ_ON) m_stat[2] = 1'b1;
        end else begin
            rx_q.push_back(v);
        end
    endtask

    task automatic tx_pop();
        @(posedge pclk); #1;
        tx_rd = 1'b1;
        @(posedge pclk); #1;
        tx_rd = 1'b0;
        if (tx_q.size() == 0) begin
            if (IRQ_ON) m_stat[3] = 1'b1;
        end else begin
            void'(tx_q.pop_front());
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d, ed;
        logic e, ee;
        flags = 13'($urandom);
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;
        model_reset();
        n_checks++;
        if (prdata !== 32'h0 || pslverr !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: prdata=%h pslverr=%b irq=%b required 0/0/0", prdata, pslverr, irq);
        end
        n_checks++;
        if (tx_empty !== 1'b1 || rx_full !== 1'b0 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fifo: tx_empty=%b rx_full=%b tx_data=%h required 1/0/0", tx_empty, rx_full, tx_data);
        end
        n_checks++;
        if (controls !== 15'h06D5) begin
            n_fail++;
            $display("FAIL reset_controls: got %h required 06d5", controls);
        end
        xfer(8'h00, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== 32'h000006D5 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_read: got %h err %b required 000006d5 err 0", d, e);
        end
        xfer(8'h04, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== {16'h0, 3'b0, flags}) begin
            n_fail++;
            $display("FAIL reset_status: got %h required %h", d, {16'h0, 3'b0, flags});
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] d, ed, v;
        logic e, ee;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            xfer(8'h00, 1'b1, v, 1'b0, d, e, ed, ee);
            n_checks++;
            if (controls !== m_ctrl || e !== ee) begin
                n_fail++;
                $display("FAIL ctrl_write: controls %h err %b required %h err %b", controls, e, m_ctrl, ee);
            end
        end
        xfer(8'h04, 1'b1, $urandom, 1'b0, d, e, ed, ee);
        xfer(8'h00, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_readback: got %h err %b required %h err 0", d, e, ed);
        end
    endtask

    task automatic test_tx_fifo();
        logic [31:0] d, ed;
        logic e, ee;
        xfer(8'h14, 1'b1, 32'h1, 1'b0, d, e, ed, ee);
        for (int i = 0; i < 4; i++) xfer(8'h08, 1'b1, 32'hA0 + i, 1'b0, d, e, ed, ee);
        xfer(8'h04, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d[23:16] !== 8'd4 || d !== ed) begin
            n_fail++;
            $display("FAIL tx_count_full: status %h required %h", d, ed);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_data !== 32'hA0 + i) begin
                n_fail++;
                $display("FAIL tx_head_%0d: got %h required %h", i, tx_data, 32'hA0 + i);
            end
            tx_pop();
        end
        n_checks++;
        if (tx_empty !== 1'b1 || tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL tx_drained: tx_empty %b tx_data %h required 1/0", tx_empty, tx_data);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d, ed;
        logic e, ee;
        for (int i = 0; i < 4; i++) xfer(8'h08, 1'b1, $urandom, 1'b0, d, e, ed, ee);
        xfer(8'h08, 1'b1, 32'hFF, 1'b0, d, e, ed, ee);
        settle();
        n_checks++;
        if (irq !== exp_irq()) begin
            n_fail++;
            $display("FAIL tx_ovf_irq: got %b required %b", irq, exp_irq());
        end
        xfer(8'h10, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== ee || (IRQ_ON && d !== 32'h1)) begin
            n_fail++;
            $display("FAIL tx_ovf_stat: got %h err %b required %h err %b", d, e, ed, ee);
        end
        xfer(8'h10, 1'b1, 32'h1, 1'b0, d, e, ed, ee);
        settle();
        xfer(8'h10, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b0 || e !== ee) begin
            n_fail++;
            $display("FAIL w1c_clear: stat %h irq %b err %b required 0 0 %b", d, irq, e, ee);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_data !== exp_head()) begin
                n_fail++;
                $display("FAIL tx_ovf_drain_%0d: got %h required %h", i, tx_data, exp_head());
            end
            tx_pop();
        end
    endtask

    task automatic test_rx_wrap();
        logic [31:0] d, ed;
        logic e, ee;
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) rx_push(32'h11 + i);
        for (int j = 0; j < 6; j++) begin
            if (j == 2) begin
                rx_push(32'h15);
                rx_push(32'h16);
            end
            xfer(8'h0C, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
            n_checks++;
            if (d !== 32'h11 + k) begin
                n_fail++;
                $display("FAIL rx_wrap_%0d: got %h required %h", k, d, 32'h11 + k);
            end
            k++;
        end
        for (int i = 0; i < 4; i++) rx_push($urandom);
        n_checks++;
        if (rx_full !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_full: got %b required 1", rx_full);
        end
        rx_push(32'hDEAD);
        xfer(8'h10, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== ee || (IRQ_ON && d[2] !== 1'b1)) begin
            n_fail++;
            $display("FAIL rx_ovf_stat: got %h err %b required %h err %b", d, e, ed, ee);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(8'h0C, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
            n_checks++;
            if (d !== ed) begin
                n_fail++;
                $display("FAIL rx_drain_%0d: got %h required %h", i, d, ed);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, ed;
        logic e, ee;
        xfer(8'h10, 1'b1, 32'hF, 1'b0, d, e, ed, ee);
        xfer(8'h0C, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_udf_read: got %h err %b required 0 err 0", d, e);
        end
        tx_pop();
        xfer(8'h10, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== ee || (IRQ_ON && d !== 32'hA)) begin
            n_fail++;
            $display("FAIL udf_stat: got %h err %b required %h err %b", d, e, ed, ee);
        end
        xfer(8'h20, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h err %b required 0 err 1", d, e);
        end
        xfer(8'h20, 1'b1, $urandom, 1'b0, d, e, ed, ee);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_write: err %b required 1", e);
        end
        xfer(8'h14, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== ee) begin
            n_fail++;
            $display("FAIL irq_en_read: got %h err %b required %h err %b", d, e, ed, ee);
        end
        xfer(8'h04, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || controls !== m_ctrl) begin
            n_fail++;
            $display("FAIL no_side_effect: status %h ctrl %h required %h %h", d, controls, ed, m_ctrl);
        end
        xfer(8'h10, 1'b1, 32'hF, 1'b0, d, e, ed, ee);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed;
        logic e, ee;
        xfer(8'h14, 1'b1, 32'($urandom_range(1, 15)), 1'b0, d, e, ed, ee);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: rx_push($urandom);
                1: begin
                       n_checks++;
                       if (tx_data !== exp_head()) begin
                           n_fail++;
                           $display("FAIL rnd_tx_head_%0d: got %h required %h", i, tx_data, exp_head());
                       end
                       xfer(8'h08, 1'b1, $urandom, 1'($urandom_range(0, 1)), d, e, ed, ee);
                   end
                2: begin
                       xfer(8'h0C, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
                       n_checks++;
                       if (d !== ed || e !== ee) begin
                           n_fail++;
                           $display("FAIL rnd_rx_read_%0d: got %h err %b required %h err %b", i, d, e, ed, ee);
                       end
                   end
                3: begin
                       n_checks++;
                       if (tx_data !== exp_head()) begin
                           n_fail++;
                           $display("FAIL rnd_tx_pop_%0d: got %h required %h", i, tx_data, exp_head());
                       end
                       tx_pop();
                   end
                default: begin
                       flags = 13'($urandom);
                       xfer(8'h04, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
                       n_checks++;
                       if (d !== ed) begin
                           n_fail++;
                           $display("FAIL rnd_status_%0d: got %h required %h", i, d, ed);
                       end
                   end
            endcase
            settle();
            n_checks++;
            if (irq !== exp_irq() || rx_full !== (rx_q.size() == DEPTH) || tx_empty !== (tx_q.size() == 0)) begin
                n_fail++;
                $display("FAIL rnd_flags_%0d: irq %b rx_full %b tx_empty %b required %b %b %b", i,
                         irq, rx_full, tx_empty, exp_irq(), rx_q.size() == DEPTH, tx_q.size() == 0);
            end
        end
        xfer(8'h10, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d !== ed || e !== ee) begin
            n_fail++;
            $display("FAIL rnd_irq_stat: got %h err %b required %h err %b", d, e, ed, ee);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] d, ed;
        logic e, ee;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h5A5A;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; preset = 1'b0;
        model_reset();
        xfer(8'h04, 1'b0, 32'h0, 1'b0, d, e, ed, ee);
        n_checks++;
        if (d[23:16] !== 8'd0 || d !== ed || tx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_xfer: status %h tx_empty %b required %h 1", d, tx_empty, ed);
        end
        n_checks++;
        if (controls !== 15'h06D5 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_regs: controls %h irq %b required 06d5 0", controls, irq);
        end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_tx_fifo();
        test_tx_overflow();
        test_rx_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
